// File: rtl/aclk_tod_counter.sv
// Time-of-day counter: BCD hours/minutes/(seconds) kept internally in 24 h form,
// with load validation, manual set strobes and a combinational 12/24 h display mapping.
module aclk_tod_counter #(
    parameter int         HAS_SEC    = 1,
    parameter logic [7:0] RST_HR_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_hr_ms,
    input  logic [3:0] ld_hr_ls,
    input  logic [3:0] ld_min_ms,
    input  logic [3:0] ld_min_ls,
    input  logic [3:0] ld_sec_ms,
    input  logic [3:0] ld_sec_ls,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       mode_12h,
    output logic [3:0] hr_ms,
    output logic [3:0] hr_ls,
    output logic [3:0] min_ms,
    output logic [3:0] min_ls,
    output logic [3:0] sec_ms,
    output logic [3:0] sec_ls,
    output logic       pm,
    output logic       day_wrap,
    output logic       load_err
);

    logic [7:0] r_hr;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic       r_day_wrap;
    logic       r_load_err;

    logic [7:0] w_hr_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic       w_dw_nxt;
    logic       w_le_nxt;
    logic       w_min_step;
    logic       w_ld_ok;
    logic [8:0] w_hr_inc;
    logic [8:0] w_min_inc;
    logic [8:0] w_sec_inc;
    logic [8:0] w_disp_hr;

    // Returns {carry, ms, ls} for a 00..59 BCD pair.
    function automatic logic [8:0] inc_60(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b1, 8'h00};
    endfunction

    function automatic logic [8:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {pm, ms, ls} of the displayed hour.
    function automatic logic [8:0] disp_hour(input logic [7:0] v, input logic mode);
        logic [4:0] h;
        logic [4:0] d;
        logic       p;
        h = 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
        if (!mode)
            return {1'b0, v};
        if (h == 5'd0) begin
            d = 5'd12;
            p = 1'b0;
        end else if (h < 5'd12) begin
            d = h;
            p = 1'b0;
        end else if (h == 5'd12) begin
            d = 5'd12;
            p = 1'b1;
        end else begin
            d = h - 5'd12;
            p = 1'b1;
        end
        if (d >= 5'd10)
            return {p, 4'd1, 4'(d - 5'd10)};
        else
            return {p, 4'd0, 4'(d)};
    endfunction

    assign w_ld_ok = (ld_hr_ms <= 4'd2) && (ld_hr_ls <= 4'd9)
                  && !((ld_hr_ms == 4'd2) && (ld_hr_ls > 4'd3))
                  && (ld_min_ms <= 4'd5) && (ld_min_ls <= 4'd9)
                  && ((HAS_SEC == 0) || ((ld_sec_ms <= 4'd5) && (ld_sec_ls <= 4'd9)));

    assign w_hr_inc  = inc_hour(r_hr);
    assign w_min_inc = inc_60(r_min);
    assign w_sec_inc = inc_60(r_sec);

    // Priority: load, then manual set strobes, then tick.
    always_comb begin
        w_hr_nxt   = r_hr;
        w_min_nxt  = r_min;
        w_sec_nxt  = r_sec;
        w_dw_nxt   = 1'b0;
        w_le_nxt   = 1'b0;
        w_min_step = 1'b0;
        if (load) begin
            if (w_ld_ok) begin
                w_hr_nxt  = {ld_hr_ms, ld_hr_ls};
                w_min_nxt = {ld_min_ms, ld_min_ls};
                if (HAS_SEC != 0)
                    w_sec_nxt = {ld_sec_ms, ld_sec_ls};
            end else begin
                w_le_nxt = 1'b1;
            end
        end else if (inc_hr || inc_min) begin
            if (inc_hr)
                w_hr_nxt = w_hr_inc[7:0];
            if (inc_min)
                w_min_nxt = w_min_inc[7:0];
        end else if (tick) begin
            if (HAS_SEC != 0) begin
                w_sec_nxt  = w_sec_inc[7:0];
                w_min_step = w_sec_inc[8];
            end else begin
                w_min_step = 1'b1;
            end
            if (w_min_step) begin
                w_min_nxt = w_min_inc[7:0];
                if (w_min_inc[8]) begin
                    w_hr_nxt = w_hr_inc[7:0];
                    w_dw_nxt = w_hr_inc[8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hr       <= RST_HR_BCD;
            r_min      <= 8'h00;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_hr       <= w_hr_nxt;
            r_min      <= w_min_nxt;
            r_day_wrap <= w_dw_nxt;
            r_load_err <= w_le_nxt;
        end
    end

    generate
        if (HAS_SEC != 0) begin : g_sec
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_sec <= 8'h00;
                else
                    r_sec <= w_sec_nxt;
            end
        end else begin : g_no_sec
            assign r_sec = 8'h00;
        end
    endgenerate

    assign w_disp_hr = disp_hour(r_hr, mode_12h);

    assign pm       = w_disp_hr[8];
    assign hr_ms    = w_disp_hr[7:4];
    assign hr_ls    = w_disp_hr[3:0];
    assign min_ms   = r_min[7:4];
    assign min_ls   = r_min[3:0];
    assign sec_ms   = r_sec[7:4];
    assign sec_ls   = r_sec[3:0];
    assign day_wrap = r_day_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_aclk_tod_counter.sv
// Directed scoreboard bench for aclk_tod_counter: one instance with seconds and
// midnight reset hour, one without seconds and a 12:00 reset hour.
module tb_aclk_tod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick, load, inc_hr, inc_min, mode_12h;
    logic       reset0, tick0, load0;
    logic [3:0] ld_hr_ms, ld_hr_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls;

    logic [3:0] a_hr_ms, a_hr_ls, a_min_ms, a_min_ls, a_sec_ms, a_sec_ls;
    logic       a_pm, a_dw, a_le;
    logic [3:0] b_hr_ms, b_hr_ls, b_min_ms, b_min_ls, b_sec_ms, b_sec_ls;
    logic       b_pm, b_dw, b_le;

    aclk_tod_counter #(.HAS_SEC(1), .RST_HR_BCD(8'h00)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .ld_hr_ms(ld_hr_ms), .ld_hr_ls(ld_hr_ls), .ld_min_ms(ld_min_ms),
        .ld_min_ls(ld_min_ls), .ld_sec_ms(ld_sec_ms), .ld_sec_ls(ld_sec_ls),
        .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
        .hr_ms(a_hr_ms), .hr_ls(a_hr_ls), .min_ms(a_min_ms), .min_ls(a_min_ls),
        .sec_ms(a_sec_ms), .sec_ls(a_sec_ls), .pm(a_pm), .day_wrap(a_dw), .load_err(a_le)
    );

    aclk_tod_counter #(.HAS_SEC(0), .RST_HR_BCD(8'h12)) u_dut_nosec (
        .clk(clk), .reset(reset0), .tick(tick0), .load(load0),
        .ld_hr_ms(ld_hr_ms), .ld_hr_ls(ld_hr_ls), .ld_min_ms(ld_min_ms),
        .ld_min_ls(ld_min_ls), .ld_sec_ms(ld_sec_ms), .ld_sec_ls(ld_sec_ls),
        .inc_hr(1'b0), .inc_min(1'b0), .mode_12h(1'b0),
        .hr_ms(b_hr_ms), .hr_ls(b_hr_ls), .min_ms(b_min_ms), .min_ls(b_min_ls),
        .sec_ms(b_sec_ms), .sec_ls(b_sec_ls), .pm(b_pm), .day_wrap(b_dw), .load_err(b_le)
    );

    typedef struct packed {
        logic        sel;
        logic [23:0] t;
        logic        p;
        logic        dw;
        logic        le;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t        e;
        string       tag;
        logic [23:0] t;
        logic        p, dw, le;
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        if (e.sel) begin
            t  = {b_hr_ms, b_hr_ls, b_min_ms, b_min_ls, b_sec_ms, b_sec_ls};
            p  = b_pm;
            dw = b_dw;
            le = b_le;
        end else begin
            t  = {a_hr_ms, a_hr_ls, a_min_ms, a_min_ls, a_sec_ms, a_sec_ls};
            p  = a_pm;
            dw = a_dw;
            le = a_le;
        end
        cmp({tag, ".time"}, t, e.t);
        cmp({tag, ".pm"}, {23'd0, p}, {23'd0, e.p});
        cmp({tag, ".day_wrap"}, {23'd0, dw}, {23'd0, e.dw});
        cmp({tag, ".load_err"}, {23'd0, le}, {23'd0, e.le});
    endtask

    task automatic push(input logic sel, input string tag, input logic [23:0] t,
                        input logic p, input logic dw, input logic le);
        exp_t e;
        e.sel = sel;
        e.t   = t;
        e.p   = p;
        e.dw  = dw;
        e.le  = le;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Combinational / asynchronous effects: check without a clock edge.
    task automatic expect_now(input logic sel, input string tag, input logic [23:0] t,
                              input logic p, input logic dw, input logic le);
        push(sel, tag, t, p, dw, le);
        #1;
        pop_check();
    endtask

    // Strobes already driven are consumed by the next edge, then cleared.
    task automatic expect_edge(input logic sel, input string tag, input logic [23:0] t,
                               input logic p, input logic dw, input logic le);
        push(sel, tag, t, p, dw, le);
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        tick0 = 1'b0; load0 = 1'b0;
        pop_check();
    endtask

    task automatic set_ld(input logic [23:0] v);
        {ld_hr_ms, ld_hr_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls} = v;
    endtask

    initial begin
        reset = 1'b1; reset0 = 1'b1;
        tick = 1'b0; load = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; mode_12h = 1'b0;
        tick0 = 1'b0; load0 = 1'b0;
        set_ld(24'h000000);

        #2;
        expect_now(1'b0, "rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        expect_now(1'b1, "rst_nosec", 24'h120000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; reset0 = 1'b0;

        set_ld(24'h235958); load = 1'b1; tick = 1'b1;
        expect_edge(1'b0, "load_with_tick", 24'h235958, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        expect_edge(1'b0, "tick_2359_59", 24'h235959, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        expect_edge(1'b0, "midnight_wrap", 24'h000000, 1'b0, 1'b1, 1'b0);
        expect_edge(1'b0, "wrap_one_cycle", 24'h000000, 1'b0, 1'b0, 1'b0);

        set_ld(24'h240000); load = 1'b1;
        expect_edge(1'b0, "bad_hour24", 24'h000000, 1'b0, 1'b0, 1'b1);
        expect_edge(1'b0, "bad_hour24_end", 24'h000000, 1'b0, 1'b0, 1'b0);
        set_ld(24'h126000); load = 1'b1;
        expect_edge(1'b0, "bad_min60", 24'h000000, 1'b0, 1'b0, 1'b1);
        expect_edge(1'b0, "bad_min60_end", 24'h000000, 1'b0, 1'b0, 1'b0);

        set_ld(24'h105930); load = 1'b1;
        expect_edge(1'b0, "load_105930", 24'h105930, 1'b0, 1'b0, 1'b0);
        inc_min = 1'b1;
        expect_edge(1'b0, "inc_min_wrap", 24'h100030, 1'b0, 1'b0, 1'b0);
        inc_min = 1'b1; tick = 1'b1;
        expect_edge(1'b0, "inc_min_over_tick", 24'h100130, 1'b0, 1'b0, 1'b0);

        set_ld(24'h230000); load = 1'b1;
        expect_edge(1'b0, "load_2300", 24'h230000, 1'b0, 1'b0, 1'b0);
        inc_hr = 1'b1;
        expect_edge(1'b0, "inc_hr_wrap", 24'h000000, 1'b0, 1'b0, 1'b0);
        inc_hr = 1'b1; inc_min = 1'b1;
        expect_edge(1'b0, "inc_both", 24'h010100, 1'b0, 1'b0, 1'b0);

        set_ld(24'h095959); load = 1'b1;
        expect_edge(1'b0, "load_095959", 24'h095959, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        expect_edge(1'b0, "hour_09_10", 24'h100000, 1'b0, 1'b0, 1'b0);
        set_ld(24'h195959); load = 1'b1;
        expect_edge(1'b0, "load_195959", 24'h195959, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        expect_edge(1'b0, "hour_19_20", 24'h200000, 1'b0, 1'b0, 1'b0);

        set_ld(24'h001500); load = 1'b1;
        expect_edge(1'b0, "load_0015", 24'h001500, 1'b0, 1'b0, 1'b0);
        mode_12h = 1'b1;
        expect_now(1'b0, "12h_midnight", 24'h121500, 1'b0, 1'b0, 1'b0);
        set_ld(24'h120000); load = 1'b1;
        expect_edge(1'b0, "12h_noon", 24'h120000, 1'b1, 1'b0, 1'b0);
        set_ld(24'h134500); load = 1'b1;
        expect_edge(1'b0, "12h_1345", 24'h014500, 1'b1, 1'b0, 1'b0);
        mode_12h = 1'b0;
        expect_now(1'b0, "24h_back_1345", 24'h134500, 1'b0, 1'b0, 1'b0);
        mode_12h = 1'b1;
        set_ld(24'h210000); load = 1'b1;
        expect_edge(1'b0, "12h_2100", 24'h090000, 1'b1, 1'b0, 1'b0);
        set_ld(24'h110000); load = 1'b1;
        expect_edge(1'b0, "12h_1100", 24'h110000, 1'b0, 1'b0, 1'b0);
        mode_12h = 1'b0;

        set_ld(24'h235959); load = 1'b1;
        expect_edge(1'b0, "load_235959", 24'h235959, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        expect_edge(1'b0, "wrap_before_rst", 24'h000000, 1'b0, 1'b1, 1'b0);
        set_ld(24'h105930); load = 1'b1; tick = 1'b1; reset = 1'b1;
        expect_now(1'b0, "async_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        expect_edge(1'b0, "rst_blocks_load", 24'h000000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick = 1'b1;
        expect_edge(1'b0, "resume_after_rst", 24'h000001, 1'b0, 1'b0, 1'b0);

        tick0 = 1'b1;
        expect_edge(1'b1, "nosec_tick1", 24'h120100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 58; i++) begin
            tick0 = 1'b1;
            @(posedge clk);
            #1;
            tick0 = 1'b0;
        end
        tick0 = 1'b1;
        expect_edge(1'b1, "nosec_tick60", 24'h130000, 1'b0, 1'b0, 1'b0);
        set_ld(24'h053099); load0 = 1'b1;
        expect_edge(1'b1, "nosec_ld_ignores_sec", 24'h053000, 1'b0, 1'b0, 1'b0);
        set_ld(24'h236000); load0 = 1'b1;
        expect_edge(1'b1, "nosec_bad_min", 24'h053000, 1'b0, 1'b0, 1'b1);
        set_ld(24'h235900); load0 = 1'b1;
        expect_edge(1'b1, "nosec_load_2359", 24'h235900, 1'b0, 1'b0, 1'b0);
        tick0 = 1'b1;
        expect_edge(1'b1, "nosec_wrap", 24'h000000, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
